// File: rtl/axis_slot_rx_dma_pkg.sv
// Shared definitions for the slot-based receive DMA: descriptor layout and FSM state encodings.
package axis_slot_rx_dma_pkg;

    localparam int LEN_LSB   = 0;
    localparam int ADDR_LSB  = 16;
    localparam int SLOT_LSB  = 32;
    localparam int PORT_LSB  = 40;
    localparam int TRUNC_BIT = 48;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_DESC  = 2'd3;

    // Field order mirrors the bit offsets above, MSB first.
    typedef struct packed {
        logic [14:0] rsvd;
        logic        trunc;
        logic [7:0]  port;
        logic [7:0]  slot;
        logic [15:0] addr;
        logic [15:0] len;
    } recv_desc_t;

endpackage

// File: rtl/axis_slot_rx_dma_slot_prio_enc.sv
// Lowest-set-bit encoder over the slot free bitmap.
module slot_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_bitmap,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest set bit is the last to be written.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_bitmap[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end else begin
                index = index;
            end
        end
    end

endmodule

// File: rtl/axis_slot_rx_dma.sv
// Receive DMA: writes AXIS packets into fixed-size memory slots and emits one descriptor per packet.
module axis_slot_rx_dma
    import axis_slot_rx_dma_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int SLOT_COUNT    = 8,
    parameter int SLOT_SIZE_LOG = 11,
    parameter int PORT_WIDTH    = 2,
    parameter int DROP_ON_FULL  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [STRB_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [PORT_WIDTH-1:0]         s_axis_tuser,
    output logic                          mem_wr_en,
    output logic [STRB_WIDTH-1:0]         mem_wr_strb,
    output logic [ADDR_WIDTH-1:0]         mem_wr_addr,
    output logic [DATA_WIDTH-1:0]         mem_wr_data,
    output logic                          mem_wr_last,
    input  logic                          mem_wr_ready,
    output logic                          recv_desc_valid,
    input  logic                          recv_desc_ready,
    output logic [63:0]                   recv_desc,
    input  logic                          slot_free_valid,
    input  logic [7:0]                    slot_free,
    output logic [31:0]                   drop_count,
    output logic [$clog2(SLOT_COUNT):0]   slots_free
);

    localparam int IDX_W  = $clog2(SLOT_COUNT);
    localparam int CNT_W  = $clog2(SLOT_COUNT) + 1;
    localparam int KCNT_W = $clog2(STRB_WIDTH) + 1;
    localparam int OFF_W  = SLOT_SIZE_LOG + 1;

    function automatic logic [KCNT_W-1:0] popcount_keep(input logic [STRB_WIDTH-1:0] keep);
        logic [KCNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            n = n + KCNT_W'(keep[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] popcount_slots(input logic [SLOT_COUNT-1:0] bits);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            n = n + CNT_W'(bits[i]);
        end
        return n;
    endfunction

    logic [1:0]            r_state;
    logic [SLOT_COUNT-1:0] r_free;
    logic [CNT_W-1:0]      r_slots_free;
    logic [IDX_W-1:0]      r_slot;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [OFF_W-1:0]      r_offset;
    logic [15:0]           r_len;
    logic [PORT_WIDTH-1:0] r_port;
    logic                  r_first;
    logic                  r_trunc;
    logic                  r_desc_valid;
    logic [63:0]           r_desc;
    logic [31:0]           r_drop_count;

    logic                  w_alloc_valid;
    logic [IDX_W-1:0]      w_alloc_idx;
    logic [SLOT_COUNT-1:0] w_alloc_clr;
    logic [SLOT_COUNT-1:0] w_free_set;
    logic [SLOT_COUNT-1:0] w_free_next;
    logic                  w_tready;
    logic                  w_accept;
    logic                  w_overflow;
    logic [15:0]           w_next_len;
    logic [PORT_WIDTH-1:0] w_port;
    recv_desc_t            w_desc;

    slot_prio_enc #(
        .N     (SLOT_COUNT),
        .IDX_W (IDX_W)
    ) u_slot_prio_enc (
        .i_bitmap (r_free),
        .valid    (w_alloc_valid),
        .index    (w_alloc_idx)
    );

    // Overflow latches once the offset has walked past the last byte of the slot.
    assign w_overflow = r_offset[SLOT_SIZE_LOG];
    assign w_accept   = s_axis_tvalid & w_tready;
    assign w_next_len = w_overflow ? r_len : (r_len + 16'(popcount_keep(s_axis_tkeep)));
    assign w_port     = r_first ? s_axis_tuser : r_port;

    assign s_axis_tready   = w_tready;
    assign mem_wr_en       = (r_state == ST_WRITE) & s_axis_tvalid & mem_wr_ready & ~w_overflow;
    assign mem_wr_addr     = r_base + ADDR_WIDTH'(r_offset[SLOT_SIZE_LOG-1:0]);
    assign mem_wr_strb     = s_axis_tkeep;
    assign mem_wr_data     = s_axis_tdata;
    assign mem_wr_last     = s_axis_tlast;
    assign recv_desc_valid = r_desc_valid;
    assign recv_desc       = r_desc;
    assign drop_count      = r_drop_count;
    assign slots_free      = r_slots_free;

    // Stream ready per state.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            ST_WRITE: w_tready = mem_wr_ready;
            ST_DROP:  w_tready = 1'b1;
            default:  w_tready = 1'b0;
        endcase
    end

    // Descriptor assembled from the running counters plus the tlast beat itself.
    always_comb begin
        w_desc       = '0;
        w_desc.len   = w_next_len;
        w_desc.addr  = 16'(r_base);
        w_desc.slot  = 8'(r_slot);
        w_desc.port  = 8'(w_port);
        w_desc.trunc = r_trunc | w_overflow;
    end

    // Bitmap updates; a free aimed at an already-free bit (incl. the one being allocated) is ignored.
    always_comb begin
        w_alloc_clr = '0;
        w_free_set  = '0;
        if ((r_state == ST_IDLE) && w_alloc_valid) begin
            w_alloc_clr[w_alloc_idx] = 1'b1;
        end else begin
            w_alloc_clr = '0;
        end
        if (slot_free_valid && (32'(slot_free) < 32'(SLOT_COUNT))) begin
            w_free_set[slot_free[IDX_W-1:0]] = 1'b1;
        end else begin
            w_free_set = '0;
        end
        w_free_next = (r_free & ~w_alloc_clr) | (w_free_set & ~r_free);
    end

    // Free bitmap and its population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_free       <= '1;
            r_slots_free <= CNT_W'(SLOT_COUNT);
        end else begin
            r_free       <= w_free_next;
            r_slots_free <= popcount_slots(w_free_next);
        end
    end

    // Packet FSM with slot bookkeeping, descriptor and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_slot       <= '0;
            r_base       <= '0;
            r_offset     <= '0;
            r_len        <= '0;
            r_port       <= '0;
            r_first      <= 1'b0;
            r_trunc      <= 1'b0;
            r_desc_valid <= 1'b0;
            r_desc       <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_alloc_valid) begin
                        r_slot   <= w_alloc_idx;
                        r_base   <= ADDR_WIDTH'(w_alloc_idx) << SLOT_SIZE_LOG;
                        r_offset <= '0;
                        r_len    <= '0;
                        r_trunc  <= 1'b0;
                        r_first  <= 1'b1;
                        r_state  <= ST_WRITE;
                    end else if ((DROP_ON_FULL != 0) && s_axis_tvalid) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        r_first <= 1'b0;
                        r_port  <= w_port;
                        r_len   <= w_next_len;
                        if (w_overflow) begin
                            r_trunc <= 1'b1;
                        end else begin
                            r_offset <= r_offset + OFF_W'(STRB_WIDTH);
                        end
                        if (s_axis_tlast) begin
                            r_desc       <= w_desc;
                            r_desc_valid <= 1'b1;
                            r_state      <= ST_DESC;
                        end
                    end
                end
                ST_DROP: begin
                    if (w_accept && s_axis_tlast) begin
                        if (r_drop_count != 32'hFFFF_FFFF) begin
                            r_drop_count <= r_drop_count + 32'd1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
                ST_DESC: begin
                    if (recv_desc_ready) begin
                        r_desc_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_slot_rx_dma.sv
// Directed/random bench for axis_slot_rx_dma: one drop-policy and one backpressure-policy instance.
module tb_axis_slot_rx_dma;

    localparam int SLOT_BYTES = 2048;
    localparam int SLOT_BEATS = SLOT_BYTES / 8;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  s;
        logic [63:0] d;
        logic        l;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tdata      [2];
    logic [7:0]  tkeep      [2];
    logic        tvalid     [2];
    logic        tready     [2];
    logic        tlast      [2];
    logic [1:0]  tuser      [2];
    logic        wen        [2];
    logic [7:0]  wstrb      [2];
    logic [15:0] waddr      [2];
    logic [63:0] wdata      [2];
    logic        wlast      [2];
    logic        mwready    [2];
    logic        dvalid     [2];
    logic        dready     [2];
    logic [63:0] desc       [2];
    logic        sfv        [2];
    logic [7:0]  sf         [2];
    logic [31:0] dcount     [2];
    logic [3:0]  sfree      [2];

    int  errors = 0;
    int  checks = 0;
    wr_t wq0[$];
    wr_t wq1[$];

    // Reference model: free bitmap, slot reserved for the next packet, drop count.
    bit  mfree [2][8];
    int  pend  [2];
    int  mdrop [2];

    always #5 clk = ~clk;

    axis_slot_rx_dma #(.DROP_ON_FULL(1)) u_dut_drop (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata[0]), .s_axis_tkeep(tkeep[0]), .s_axis_tvalid(tvalid[0]),
        .s_axis_tready(tready[0]), .s_axis_tlast(tlast[0]), .s_axis_tuser(tuser[0]),
        .mem_wr_en(wen[0]), .mem_wr_strb(wstrb[0]), .mem_wr_addr(waddr[0]),
        .mem_wr_data(wdata[0]), .mem_wr_last(wlast[0]), .mem_wr_ready(mwready[0]),
        .recv_desc_valid(dvalid[0]), .recv_desc_ready(dready[0]), .recv_desc(desc[0]),
        .slot_free_valid(sfv[0]), .slot_free(sf[0]),
        .drop_count(dcount[0]), .slots_free(sfree[0])
    );

    axis_slot_rx_dma #(.DROP_ON_FULL(0)) u_dut_bp (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata[1]), .s_axis_tkeep(tkeep[1]), .s_axis_tvalid(tvalid[1]),
        .s_axis_tready(tready[1]), .s_axis_tlast(tlast[1]), .s_axis_tuser(tuser[1]),
        .mem_wr_en(wen[1]), .mem_wr_strb(wstrb[1]), .mem_wr_addr(waddr[1]),
        .mem_wr_data(wdata[1]), .mem_wr_last(wlast[1]), .mem_wr_ready(mwready[1]),
        .recv_desc_valid(dvalid[1]), .recv_desc_ready(dready[1]), .recv_desc(desc[1]),
        .slot_free_valid(sfv[1]), .slot_free(sf[1]),
        .drop_count(dcount[1]), .slots_free(sfree[1])
    );

    // Capture every memory write half a cycle before the edge that commits it.
    always @(negedge clk) begin
        if (wen[0] === 1'b1) wq0.push_back({waddr[0], wstrb[0], wdata[0], wlast[0]});
        if (wen[1] === 1'b1) wq1.push_back({waddr[1], wstrb[1], wdata[1], wlast[1]});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_alloc(input int d);
        if (pend[d] < 0) begin
            for (int i = 0; i < 8; i++) begin
                if (mfree[d][i] && pend[d] < 0) begin
                    pend[d]     = i;
                    mfree[d][i] = 1'b0;
                end
            end
        end
    endfunction

    function automatic void model_reset(input int d);
        for (int i = 0; i < 8; i++) mfree[d][i] = 1'b1;
        pend[d]  = -1;
        mdrop[d] = 0;
        model_alloc(d);
    endfunction

    function automatic int model_nfree(input int d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mfree[d][i]);
        return n;
    endfunction

    task automatic do_free(input int d, input int idx);
        @(posedge clk); #1;
        sfv[d] = 1'b1;
        sf[d]  = 8'(idx);
        @(posedge clk); #1;
        sfv[d] = 1'b0;
        if (idx < 8) mfree[d][idx] = 1'b1;
        model_alloc(d);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_free(input int d, input string tag);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(tag, 64'(sfree[d]), 64'(model_nfree(d)));
    endtask

    // Drive one packet; expectations come from slot/byte arithmetic on the beat list.
    task automatic send_pkt(input int d, input int nbytes, input int port, input bit toggle, input int hold);
        int          nbeats, k, cyc, slot, nexp, exp_len;
        bit          exp_tr;
        logic [7:0]  keeps[$];
        logic [63:0] datas[$];
        wr_t         got[$];
        logic [63:0] exp_desc;
        nbeats = (nbytes + 7) / 8;
        for (int i = 0; i < nbeats; i++) begin
            int rem = nbytes - 8 * i;
            keeps.push_back(rem >= 8 ? 8'hFF : 8'((1 << rem) - 1));
            datas.push_back({$urandom, $urandom});
        end
        if (d == 0) wq0.delete(); else wq1.delete();
        k = 0; cyc = 0; slot = -1;
        @(posedge clk); #1;
        while (k < nbeats && cyc < 20000) begin
            tvalid[d]  = 1'b1;
            tdata[d]   = datas[k];
            tkeep[d]   = keeps[k];
            tlast[d]   = (k == nbeats - 1);
            tuser[d]   = (k == 0) ? 2'(port) : 2'($urandom);
            mwready[d] = toggle ? cyc[0] : 1'b1;
            @(negedge clk);
            if (tready[d] === 1'b1) begin
                if (k == 0) slot = pend[d];
                k++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        tvalid[d] = 1'b0; tlast[d] = 1'b0; mwready[d] = 1'b1;
        if (k < nbeats) check("pkt_timeout", 64'(k), 64'(nbeats));
        got = (d == 0) ? wq0 : wq1;
        nexp = (slot < 0) ? 0 : ((nbeats < SLOT_BEATS) ? nbeats : SLOT_BEATS);
        check("wr_count", 64'(got.size()), 64'(nexp));
        exp_len = 0;
        for (int i = 0; i < nexp; i++) begin
            exp_len += $countones(keeps[i]);
            if (i < got.size()) begin
                check("wr_addr", 64'(got[i].a), 64'(slot * SLOT_BYTES + 8 * i));
                check("wr_strb", 64'(got[i].s), 64'(keeps[i]));
                check("wr_data", got[i].d, datas[i]);
                check("wr_last", 64'(got[i].l), 64'(i == nbeats - 1));
            end
        end
        if (slot < 0) begin
            mdrop[d]++;
            @(negedge clk);
            check("drop_count", 64'(dcount[d]), 64'(mdrop[d]));
            check("drop_no_desc", 64'(dvalid[d]), 64'd0);
        end else begin
            exp_tr   = (nbeats > SLOT_BEATS);
            exp_desc = 64'(exp_len) | (64'(slot * SLOT_BYTES) << 16) | (64'(slot) << 32)
                     | (64'(port) << 40) | (64'(exp_tr) << 48);
            @(negedge clk);
            check("desc_valid", 64'(dvalid[d]), 64'd1);
            check("desc", desc[d], exp_desc);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("desc_hold_valid", 64'(dvalid[d]), 64'd1);
                check("desc_hold", desc[d], exp_desc);
            end
            dready[d] = 1'b1;
            @(posedge clk); #1;
            dready[d] = 1'b0;
            pend[d] = -1;
            model_alloc(d);
        end
    endtask

    initial begin
        int acc, cyc;
        for (int d = 0; d < 2; d++) begin
            tdata[d] = '0; tkeep[d] = '0; tvalid[d] = 1'b0; tlast[d] = 1'b0; tuser[d] = '0;
            mwready[d] = 1'b1; dready[d] = 1'b0; sfv[d] = 1'b0; sf[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_desc_valid", 64'(dvalid[d]), 64'd0);
            check("rst_desc", desc[d], 64'd0);
            check("rst_drop_count", 64'(dcount[d]), 64'd0);
            check("rst_slots_free", 64'(sfree[d]), 64'd8);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(0);
        model_reset(1);

        // Basic 20-byte packet on port 2, then a stalled one, then fill the rest.
        send_pkt(0, 20, 2, 1'b0, 0);
        send_pkt(0, 61, 1, 1'b1, 5);
        for (int p = 2; p < 8; p++) send_pkt(0, int'($urandom_range(1, 300)), int'($urandom_range(0, 3)), 1'b0, 0);
        check_free(0, "drop_full_slots_free");
        send_pkt(0, 40, 1, 1'b0, 0);
        check("drop_after_9th", 64'(dcount[0]), 64'd1);
        do_free(0, 3);
        send_pkt(0, 33, 3, 1'b0, 0);

        // Backpressure instance: fill, then a blocked packet released by freeing slot 3.
        for (int p = 0; p < 8; p++) send_pkt(1, int'($urandom_range(1, 300)), int'($urandom_range(0, 3)), 1'b0, 0);
        fork
            send_pkt(1, 40, 1, 1'b0, 0);
            begin
                repeat (20) begin
                    @(negedge clk);
                    check("bp_tready_low", 64'(tready[1]), 64'd0);
                end
                do_free(1, 3);
            end
        join
        check("bp_no_drop", 64'(dcount[1]), 64'd0);

        // Oversize packet truncated at the slot boundary.
        do_free(1, 0);
        send_pkt(1, 2100, 2, 1'b0, 0);
        do_free(1, 8);
        do_free(1, 200);
        check_free(1, "free_out_of_range");

        // Reset in the middle of a packet on the drop instance.
        do_free(0, 5);
        @(posedge clk); #1;
        tvalid[0] = 1'b1; tkeep[0] = 8'hFF; tlast[0] = 1'b0; tuser[0] = 2'd1;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 100) begin
            tdata[0] = {$urandom, $urandom};
            @(negedge clk);
            if (tready[0] === 1'b1) acc++;
            cyc++;
            @(posedge clk); #1;
        end
        check("mid_rst_beats", 64'(acc), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_desc_valid", 64'(dvalid[0]), 64'd0);
        check("mid_rst_desc", desc[0], 64'd0);
        check("mid_rst_drop_count", 64'(dcount[0]), 64'd0);
        check("mid_rst_slots_free", 64'(sfree[0]), 64'd8);
        check("mid_rst_tready", 64'(tready[0]), 64'd0);
        check("mid_rst_wr_en", 64'(wen[0]), 64'd0);
        check("mid_rst_slots_free_bp", 64'(sfree[1]), 64'd8);
        tvalid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        send_pkt(0, 24, 3, 1'b0, 0);
        check_free(0, "post_rst_slots_free");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
